montacargas_request_scheduler: RTL and testbench
================================================

# montacargas_request_scheduler

Call-request scheduler placed between the floor push-buttons and `montacargas_StateMachine`. It synchronises and debounces the three raw call buttons, latches pending calls, tracks the cabin floor from the limit switches, and selects one target floor at a time in SCAN order. The target is presented to the state machine on its `P1`/`P2`/`P3` inputs, so that block always sees exactly one clean, held request.

## Interface
- `DEBOUNCE_CYCLES`, default 80000: consecutive stable cycles (20 ms at 4 MHz) before a button level is accepted.
- `CNT_W`, default 17: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clockBase_4MHz`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btnRaw`  in  3  raw, asynchronous call buttons; bit0 = floor 1, bit2 = floor 3.
- `FC1`, `FC2`, `FC3`  in  1 each  floor limit switches, level high at floor.
- `SPC`  in  1  door-closed sensor, 1 = closed.
- `driverMotor`  in  2  motor command from the state machine: 00 stop, 01 up, 10 down.
- `P1`, `P2`, `P3`  out  1 each  registered request lines to the state machine; at most one high.
- `pendiente`  out  3  pending-call mask, used for LEDs.
- `dirSubida`  out  1  scan direction, 1 = up.

## Operation
- Input path: each `btnRaw` bit goes through a 2-FF synchroniser, then the debouncer (see Configuration). A press event is a one-cycle pulse on the accepted 0→1 transition.
- Floor tracking: `curFloor` (2 bits, values 1..3) loads k whenever `FCk` = 1. If several FC inputs are high at once, the highest-numbered one wins.
- Latching: a press event for floor k sets `pendiente[k]`, except when all of the following hold: k == `curFloor`, `FCk` = 1 and `driverMotor` == 00. In that case the press is dropped.
- Clearing: `pendiente[k]` clears when `FCk` = 1 and `driverMotor` == 00. If a clear and a press for the same floor occur in the same cycle, the clear wins.
- Selection, evaluated only in IDLE, with candidates = `pendiente` excluding `curFloor`:
  - `dirSubida` = 1: pick the lowest candidate above `curFloor`. If none, set `dirSubida` = 0 and pick the highest candidate below.
  - `dirSubida` = 0: the mirror image of the rule above.
  - No candidate: stay in IDLE.
- FSM states:
  - IDLE: all P outputs low. A valid selection registers `target` → ISSUE. `driverMotor` != 00 (e.g. the state machine's own timeout descent) → MOVING with `target` = 1.
  - ISSUE: drive P`target` high. It stays high indefinitely while the door is open. When `driverMotor` != 00, go → MOVING and deassert P.
  - MOVING: when `driverMotor` == 00 and `FC[target]` = 1, go → IDLE. If `driverMotor` == 00 and `FC[target]` = 0 for more than 2 cycles, which means the cabin stopped at another floor, go → IDLE without clearing the target's pending bit.
- `dirSubida` also updates in MOVING: it follows `driverMotor` (01 sets it to 1, 10 sets it to 0).

## Timing
- Reset values: `P1`/`P2`/`P3` = 0, `pendiente` = 000, `dirSubida` = 0, `curFloor` = 1, state = IDLE, all debounce counters = 0, synchronisers = 0.
- Button to `pendiente`:
  - With the macro: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
  - Without the macro: 3 cycles.
- IDLE to P high: 1 cycle for the registered target, so P rises 2 cycles after `pendiente` sets.
- Handshake: P falls in the cycle after `driverMotor` is first seen != 00. P never changes floor while asserted.
- Arrival: `pendiente` clears in the first cycle with `FCk` = 1 and `driverMotor` == 00. IDLE is re-entered in that same cycle.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and P drops at once. Pending calls are lost.

## Configuration
- `MONTACARGAS_DEBOUNCE_EN` defined: one CNT_W counter per button. The counter resets whenever the synchronised level differs from the accepted level. The new level is accepted when the counter reaches DEBOUNCE_CYCLES−1.
- Not defined: no counters. The synchronised level is accepted directly, and DEBOUNCE_CYCLES/CNT_W are unused.

## Test plan
- Reset with `FC1` = 1, `SPC` = 1, no presses → P = 000, `pendiente` = 000, `dirSubida` = 0 for 100 cycles.
- `curFloor` = 1, press floor 3 for 25 ms (macro on) → `pendiente` = 100, then `P3` = 1 two cycles later. Drive `driverMotor` = 01 → `P3` = 0 next cycle. Drive `FC3` = 1 and `driverMotor` = 00 → `pendiente` = 000, IDLE.
- Bounce floor-2 button: 5 µs pulses for 10 ms, then released → `pendiente` unchanged (macro on). Same stimulus with the macro off → `pendiente[1]` sets.
- At floor 2 moving up (`dirSubida` = 1), pending floors 1 and 3 → `P3` first. After arrival at 3: `dirSubida` = 0, then `P1`.
- At floor 1 stopped with `FC1` = 1, press floor 1 → `pendiente` stays 000 and P stays low.
- `P2` asserted in ISSUE, pulse `reset` for 1 cycle → next cycle P = 000, `pendiente` = 000, `curFloor` = 1.

Source files
------------

// File: rtl/montacargas_request_scheduler.sv
// Call-request scheduler for the montacargas lift: syncs/debounces buttons, latches calls,
// tracks the cabin floor and hands one SCAN-ordered target at a time to the state machine.
// Optional debouncer enabled by defining MONTACARGAS_DEBOUNCE_EN.
module montacargas_request_scheduler #(
    parameter int DEBOUNCE_CYCLES = 80000,
    parameter int CNT_W           = 17
) (
    input  logic       clockBase_4MHz,
    input  logic       reset,
    input  logic [2:0] btnRaw,
    input  logic       FC1,
    input  logic       FC2,
    input  logic       FC3,
    input  logic       SPC,
    input  logic [1:0] driverMotor,
    output logic       P1,
    output logic       P2,
    output logic       P3,
    output logic [2:0] pendiente,
    output logic       dirSubida
);

    typedef enum logic [1:0] {IDLE, ISSUE, MOVING} state_t;

    function automatic logic [2:0] floor_mask(input logic [1:0] f);
        case (f)
            2'd1:    floor_mask = 3'b001;
            2'd2:    floor_mask = 3'b010;
            2'd3:    floor_mask = 3'b100;
            default: floor_mask = 3'b000;
        endcase
    endfunction

    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0] lvl_prev_q, lvl_prev_d;
    logic [2:0] level, press;
    logic [1:0] cur_floor_q, cur_floor_d;
    logic [2:0] pend_q, pend_d;
    logic       dir_q, dir_d;
    state_t     state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [2:0] p_q, p_d;
    logic [1:0] stop_cnt_q, stop_cnt_d;

    logic [2:0] fc;
    logic       motor_stop;
    logic       unused_sig;

    assign fc         = {FC3, FC2, FC1};
    assign motor_stop = (driverMotor == 2'b00);

`ifdef MONTACARGAS_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       deb_q, deb_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clockBase_4MHz) begin
        if (reset) begin
            // NOTE: this array is three counters, not a RAM, so resetting it costs nothing extra.
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            deb_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            deb_q <= deb_d;
        end
    end

    assign level      = deb_q;
    assign unused_sig = SPC;
`else
    assign level      = sync2_q;
    assign unused_sig = SPC ^ DEBOUNCE_CYCLES[0] ^ CNT_W[0];
`endif

    assign press = level & ~lvl_prev_q;

    // Input path, floor tracking and call latching.
    always_comb begin
        sync1_d    = btnRaw;
        sync2_d    = sync1_q;
        lvl_prev_d = level;
        cur_floor_d = cur_floor_q;
        if (FC1) cur_floor_d = 2'd1;
        if (FC2) cur_floor_d = 2'd2;
        if (FC3) cur_floor_d = 2'd3;
        // A press at the floor we are parked at is swallowed by the same-cycle clear.
        pend_d = (pend_q | press) & ~(fc & {3{motor_stop}});
    end

    logic [2:0] cand;
    logic       have_above, have_below;
    logic [1:0] above_floor, below_floor;

    always_comb begin
        cand        = pend_q & ~floor_mask(cur_floor_q);
        have_above  = 1'b0;
        have_below  = 1'b0;
        above_floor = 2'd0;
        below_floor = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (cand[k] && (2'(k + 1) > cur_floor_q)) begin
                have_above  = 1'b1;
                above_floor = 2'(k + 1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (cand[k] && (2'(k + 1) < cur_floor_q)) begin
                have_below  = 1'b1;
                below_floor = 2'(k + 1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        dir_d      = dir_q;
        stop_cnt_d = '0;
        p_d        = '0;
        case (state_q)
            IDLE: begin
                if (!motor_stop) begin
                    state_d  = MOVING;
                    target_d = 2'd1;
                end else if (dir_q ? have_above : have_below) begin
                    state_d  = ISSUE;
                    target_d = dir_q ? above_floor : below_floor;
                end else if (dir_q ? have_below : have_above) begin
                    state_d  = ISSUE;
                    target_d = dir_q ? below_floor : above_floor;
                    dir_d    = ~dir_q;
                end
            end
            ISSUE: begin
                if (!motor_stop) state_d = MOVING;
                else             p_d     = floor_mask(target_q);
            end
            MOVING: begin
                if (driverMotor == 2'b01)      dir_d = 1'b1;
                else if (driverMotor == 2'b10) dir_d = 1'b0;
                if (motor_stop) begin
                    // Stopped somewhere other than the target for a third cycle: give up, keep the call.
                    if (|(fc & floor_mask(target_q)) || stop_cnt_q == 2'd2) state_d = IDLE;
                    else stop_cnt_d = stop_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clockBase_4MHz) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_prev_q  <= '0;
            cur_floor_q <= 2'd1;
            pend_q      <= '0;
            dir_q       <= 1'b0;
            state_q     <= IDLE;
            target_q    <= 2'd1;
            p_q         <= '0;
            stop_cnt_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            lvl_prev_q  <= lvl_prev_d;
            cur_floor_q <= cur_floor_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            state_q     <= state_d;
            target_q    <= target_d;
            p_q         <= p_d;
            stop_cnt_q  <= stop_cnt_d;
        end
    end

    assign {P3, P2, P1} = p_q;
    assign pendiente    = pend_q;
    assign dirSubida    = dir_q;

endmodule

// File: tb/tb_montacargas_request_scheduler.sv
// Self-checking bench for montacargas_request_scheduler: vector table with a scoreboard queue,
// plus hand-written sequences for latency, SCAN order, stop-elsewhere timeout and reset.
module tb_montacargas_request_scheduler;

    localparam int DEB = 8;
`ifdef MONTACARGAS_DEBOUNCE_EN
    localparam int LAT = 2 + DEB + 1;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = '0;
    logic       fc1 = 1'b0, fc2 = 1'b0, fc3 = 1'b0, spc = 1'b1;
    logic [1:0] motor = 2'b00;
    logic       p1, p2, p3, dir;
    logic [2:0] pend;
    logic [2:0] p;

    int tests  = 0;
    int failed = 0;

    assign p = {p3, p2, p1};

    montacargas_request_scheduler #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
        .clockBase_4MHz(clk), .reset(reset), .btnRaw(btn),
        .FC1(fc1), .FC2(fc2), .FC3(fc3), .SPC(spc), .driverMotor(motor),
        .P1(p1), .P2(p2), .P3(p3), .pendiente(pend), .dirSubida(dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] fc;
        logic [2:0] btn;
        logic [2:0] exp_pend;
        logic [2:0] exp_p;
        logic       exp_dir;
    } vec_t;

    typedef struct {
        logic [2:0] pend;
        logic [2:0] p;
        logic       dir;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic set_fc(input logic [2:0] f);
        {fc3, fc2, fc1} = f;
    endtask

    task automatic do_reset(input logic [2:0] f);
        reset = 1'b1;
        btn   = '0;
        motor = 2'b00;
        set_fc(f);
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic [2:0] mask);
        btn = mask;
        tick(HOLD);
        btn = '0;
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{3'b001, 3'b100, 3'b100, 3'b100, 1'b1};
        vecs[1] = '{3'b001, 3'b001, 3'b000, 3'b000, 1'b0};
        vecs[2] = '{3'b010, 3'b101, 3'b101, 3'b001, 1'b0};
        vecs[3] = '{3'b100, 3'b011, 3'b011, 3'b010, 1'b0};
        vecs[4] = '{3'b001, 3'b110, 3'b110, 3'b010, 1'b1};
        vecs[5] = '{3'b010, 3'b010, 3'b000, 3'b000, 1'b0};
        vecs[6] = '{3'b100, 3'b100, 3'b000, 3'b000, 1'b0};
        vecs[7] = '{3'b010, 3'b100, 3'b100, 3'b100, 1'b1};

        // Quiet reset: nothing may move for 100 cycles.
        do_reset(3'b001);
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (c % 25 == 24) begin
                check("quiet_p", 8'(p), 8'h0);
                check("quiet_pend", 8'(pend), 8'h0);
                check("quiet_dir", 8'(dir), 8'h0);
            end
        end

        // Vector table: parked at a floor, press a button mask, read back selection.
        for (int v = 0; v < 8; v++) begin
            do_reset(vecs[v].fc);
            tick(2);
            sb.push_back('{vecs[v].exp_pend, vecs[v].exp_p, vecs[v].exp_dir});
            press(vecs[v].btn);
            tick(3);
            e = sb.pop_front();
            check($sformatf("vec%0d_pend", v), 8'(pend), 8'(e.pend));
            check($sformatf("vec%0d_p", v), 8'(p), 8'(e.p));
            check($sformatf("vec%0d_dir", v), 8'(dir), 8'(e.dir));
        end

        // Exact latency, handshake and arrival: floor 1 calls floor 3.
        do_reset(3'b001);
        tick(2);
        btn = 3'b100;
        tick(LAT - 1);
        check("lat_pend_early", 8'(pend), 8'h0);
        tick(1);
        check("lat_pend", 8'(pend), 8'h4);
        tick(1);
        check("lat_p_early", 8'(p), 8'h0);
        tick(1);
        check("lat_p", 8'(p), 8'h4);
        btn = '0;
        tick(5);
        check("p_held", 8'(p), 8'h4);
        motor = 2'b01;
        tick(1);
        check("handshake_p", 8'(p), 8'h0);
        fc1 = 1'b0;
        tick(3);
        fc3 = 1'b1;
        motor = 2'b00;
        tick(1);
        check("arrive_pend", 8'(pend), 8'h0);
        check("arrive_dir", 8'(dir), 8'h1);
        tick(3);
        check("arrive_idle_p", 8'(p), 8'h0);

        // SCAN order: at floor 2 heading up with calls at 1 and 3.
        do_reset(3'b001);
        tick(2);
        press(3'b010);
        tick(2);
        check("scan_p2", 8'(p), 8'h2);
        motor = 2'b01;
        tick(1);
        fc1 = 1'b0;
        press(3'b101);
        tick(2);
        check("scan_pend", 8'(pend), 8'h7);
        fc2 = 1'b1;
        motor = 2'b00;
        tick(4);
        check("scan_p3_first", 8'(p), 8'h4);
        check("scan_dir_up", 8'(dir), 8'h1);
        motor = 2'b01;
        tick(1);
        fc2 = 1'b0;
        tick(2);
        fc3 = 1'b1;
        motor = 2'b00;
        tick(1);
        check("scan_pend_at3", 8'(pend), 8'h1);
        tick(3);
        check("scan_p1_next", 8'(p), 8'h1);
        check("scan_dir_down", 8'(dir), 8'h0);

        // Cabin stops at floor 2 while targeting 3: give up after 3 stopped cycles, reissue.
        do_reset(3'b001);
        tick(2);
        press(3'b100);
        tick(1);
        motor = 2'b01;
        tick(1);
        fc1 = 1'b0;
        tick(2);
        fc2 = 1'b1;
        motor = 2'b00;
        tick(4);
        check("stop_p_low", 8'(p), 8'h0);
        check("stop_pend_kept", 8'(pend), 8'h4);
        tick(1);
        check("stop_reissue_p3", 8'(p), 8'h4);

        // Bounce on floor 2 button.
        do_reset(3'b001);
        tick(2);
`ifdef MONTACARGAS_DEBOUNCE_EN
        for (int b = 0; b < 10; b++) begin
            btn = 3'b010;
            tick(1);
            btn = 3'b000;
            tick(1);
        end
        tick(LAT + 2);
        check("bounce_pend", 8'(pend), 8'h0);
`else
        btn = 3'b010;
        tick(1);
        btn = 3'b000;
        tick(LAT + 2);
        check("bounce_pend", 8'(pend), 8'h2);
`endif

        // Reset pulse while P2 is asserted.
        do_reset(3'b001);
        tick(2);
        press(3'b010);
        tick(1);
        check("rst_pre_p2", 8'(p), 8'h2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_p", 8'(p), 8'h0);
        check("rst_pend", 8'(pend), 8'h0);
        check("rst_dir", 8'(dir), 8'h0);
        tick(4);
        check("rst_stays_idle", 8'(p), 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
